// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: transfer sizes, FSM states, strobes.
package mem_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [3:0] STRB_NONE = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } mem_state_e;
endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobe/replication and load shift/extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = shifted;
        // size 2'b11 falls through to word handling
        case (size)
            SZ_B: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sign & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sign & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: latches the M-stage request, runs the req/addr_ok/data_ok
// handshake and stalls the pipeline until the access completes.
//
//   state | meaning
//   IDLE  | no access; starts on a clean, aligned, unflushed request
//   REQ   | data_req high, waiting for addr_ok (never withdrawn)
//   WAIT  | address accepted, waiting for data_ok
//   DONE  | result valid, waiting for the pipeline to advance
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic              mem_sign,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              pipe_stall,
    input  logic              flush,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              addr_err,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_data_ok
);
    mem_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              cancel_q, cancel_d;
    logic              stall;
    logic              complete;
    logic [3:0]        lane_wstrb;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;

    mem_lane_align u_lane (
        .size      (size_q),
        .sign      (sign_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (data_rdata),
        .wstrb     (lane_wstrb),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    always_comb begin
        addr_err = 1'b0;
        if (mem_en) begin
            if (mem_size == SZ_H) begin
                addr_err = mem_addr[0];
            end else if (mem_size != SZ_B) begin
                addr_err = |mem_addr[1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        sign_d   = sign_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cancel_d = cancel_q;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cancel_d = 1'b0;
                if (mem_en && !addr_err && !flush) begin
                    we_d    = mem_we;
                    size_d  = mem_size;
                    sign_d  = mem_sign;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    stall   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (flush) cancel_d = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) complete = 1'b1;
                    else              state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (flush) cancel_d = 1'b1;
                if (data_data_ok) complete = 1'b1;
            end
            ST_DONE: begin
                if (!pipe_stall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // a flush arriving on the completing cycle still cancels the result
        if (complete) begin
            if (cancel_q || flush) begin
                cancel_d = 1'b0;
                state_d  = ST_IDLE;
            end else begin
                state_d = ST_DONE;
                if (!we_q) rdata_d = lane_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            sign_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            sign_q   <= sign_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cancel_q <= cancel_d;
        end
    end

    assign mem_stall  = rst & stall;
    assign mem_rdata  = rdata_q;
    assign data_req   = (state_q == ST_REQ);
    assign data_wr    = data_req & we_q;
    assign data_wstrb = (data_req && we_q) ? lane_wstrb : STRB_NONE;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = lane_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a scripted bus slave.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en, mem_we, mem_sign, pipe_stall, flush;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_stall, addr_err, data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;

    int n_vec = 0;
    int n_err = 0;
    int req_edges = 0;
    logic req_prev = 1'b0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_size     (mem_size),
        .mem_sign     (mem_sign),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .pipe_stall   (pipe_stall),
        .flush        (flush),
        .mem_rdata    (mem_rdata),
        .mem_stall    (mem_stall),
        .addr_err     (addr_err),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_rdata   (data_rdata),
        .data_data_ok (data_data_ok)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_req && !req_prev) req_edges++;
        req_prev = data_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts at a negedge with the FSM idle; returns at the negedge after data_ok.
    task automatic run_access(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [31:0] ad, input logic [31:0] wd,
                              input int a_lat, input int d_lat, input logic [31:0] rd,
                              input logic fl_wait, output int stalls,
                              output logic [31:0] c_wdata, output logic [3:0] c_wstrb,
                              output logic c_wr, output logic [31:0] c_addr);
        int rq, wc, ph;
        logic fin, capd;
        stalls = 0; rq = 0; wc = 0; ph = 0; fin = 1'b0; capd = 1'b0;
        c_wdata = '0; c_wstrb = '0; c_wr = 1'b0; c_addr = '0;
        mem_en = 1'b1; mem_we = we; mem_size = sz; mem_sign = sg;
        mem_addr = ad; mem_wdata = wd;
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            data_addr_ok = 1'b0; data_data_ok = 1'b0; flush = 1'b0;
            data_rdata = 32'hA5A5_A5A5;
            if (ph == 0 && data_req) begin
                if (rq == a_lat) begin
                    data_addr_ok = 1'b1;
                    ph = 1;
                    if (d_lat == 0) begin
                        data_data_ok = 1'b1;
                        data_rdata = rd;
                    end
                end
                rq++;
            end else if (ph == 1) begin
                flush = fl_wait;
                wc++;
                if (wc == d_lat) begin
                    data_data_ok = 1'b1;
                    data_rdata = rd;
                end
            end
            #1;
            if (data_req && !capd) begin
                capd = 1'b1;
                c_wdata = data_wdata; c_wstrb = data_wstrb; c_wr = data_wr; c_addr = data_addr;
            end
            if (mem_stall) stalls++;
            fin = data_data_ok;
            @(negedge clk);
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b0; flush = 1'b0;
        data_rdata = 32'hA5A5_A5A5;
        if (!fin) check_vec("access_timeout", 32'd0, 32'd1);
        if (fl_wait) mem_en = 1'b0;
    endtask

    task automatic retire(input int hold, input logic [31:0] exp_rd);
        for (int i = 0; i < hold; i++) begin
            pipe_stall = 1'b1;
            #1;
            check_vec("hold_stall", {31'd0, mem_stall}, 32'd0);
            check_vec("hold_rdata", mem_rdata, exp_rd);
            @(negedge clk);
        end
        pipe_stall = 1'b0;
        #1;
        check_vec("done_stall", {31'd0, mem_stall}, 32'd0);
        check_vec("done_rdata", mem_rdata, exp_rd);
        @(negedge clk);
        mem_en = 1'b0;
    endtask

    int          st, e0;
    logic [31:0] cw, ca;
    logic [3:0]  cs;
    logic        cr;

    initial begin
        rst = 1'b0; mem_en = 1'b0; mem_we = 1'b0; mem_size = SZ_B; mem_sign = 1'b0;
        mem_addr = '0; mem_wdata = '0; pipe_stall = 1'b0; flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check_vec("rst_stall", {31'd0, mem_stall}, 32'd0);
        check_vec("rst_req", {31'd0, data_req}, 32'd0);
        check_vec("rst_wr", {31'd0, data_wr}, 32'd0);
        check_vec("rst_wstrb", {28'd0, data_wstrb}, 32'd0);
        check_vec("rst_rdata", mem_rdata, 32'd0);
        check_vec("rst_addr", data_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // word load, addr_ok in REQ, data_ok two cycles later
        e0 = req_edges;
        run_access(1'b0, SZ_W, 1'b0, 32'h0000_1000, 32'h0, 0, 2, 32'hDEAD_BEEF, 1'b0, st, cw, cs, cr, ca);
        check_vec("wl_stalls", st, 32'd4);
        check_vec("wl_addr", ca, 32'h0000_1000);
        check_vec("wl_wstrb", {28'd0, cs}, 32'd0);
        check_vec("wl_wr", {31'd0, cr}, 32'd0);
        retire(0, 32'hDEAD_BEEF);
        check_vec("wl_reqs", req_edges - e0, 32'd1);

        // byte load at lane 3, signed then unsigned
        run_access(1'b0, SZ_B, 1'b1, 32'h0000_1003, 32'h0, 1, 1, 32'h80FF_FFFF, 1'b0, st, cw, cs, cr, ca);
        check_vec("bls_stalls", st, 32'd4);
        retire(0, 32'hFFFF_FF80);
        run_access(1'b0, SZ_B, 1'b0, 32'h0000_1003, 32'h0, 0, 1, 32'h80FF_FFFF, 1'b0, st, cw, cs, cr, ca);
        retire(0, 32'h0000_0080);

        // half store on upper half
        run_access(1'b1, SZ_H, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 0, 1, 32'h1111_2222, 1'b0, st, cw, cs, cr, ca);
        check_vec("hs_wdata", cw, 32'hABCD_ABCD);
        check_vec("hs_wstrb", {28'd0, cs}, 32'h0000_000C);
        check_vec("hs_wr", {31'd0, cr}, 32'd1);
        check_vec("hs_addr", ca, 32'h0000_2002);
        check_vec("hs_stalls", st, 32'd3);
        retire(0, 32'h0000_0080);

        // misaligned word and half; aligned half with flush suppressed
        e0 = req_edges;
        mem_en = 1'b1; mem_we = 1'b0; mem_size = SZ_W; mem_addr = 32'h0000_1002;
        #1;
        check_vec("mis_w_err", {31'd0, addr_err}, 32'd1);
        check_vec("mis_w_stall", {31'd0, mem_stall}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check_vec("mis_w_req", {31'd0, data_req}, 32'd0);
        mem_size = SZ_H; mem_addr = 32'h0000_1001;
        #1;
        check_vec("mis_h_err", {31'd0, addr_err}, 32'd1);
        @(negedge clk);
        mem_addr = 32'h0000_1002; flush = 1'b1;
        #1;
        check_vec("al_h_err", {31'd0, addr_err}, 32'd0);
        check_vec("fl_idle_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        #1;
        check_vec("fl_idle_req", {31'd0, data_req}, 32'd0);
        check_vec("mis_reqs", req_edges - e0, 32'd0);
        @(negedge clk);
        mem_en = 1'b0; flush = 1'b0;
        @(negedge clk);

        // signed half load held in DONE by pipe_stall
        e0 = req_edges;
        run_access(1'b0, SZ_H, 1'b1, 32'h0000_1002, 32'h0, 0, 1, 32'h8001_1234, 1'b0, st, cw, cs, cr, ca);
        retire(3, 32'hFFFF_8001);
        check_vec("hold_reqs", req_edges - e0, 32'd1);

        // flush during WAIT: handshake completes, result discarded
        run_access(1'b0, SZ_W, 1'b0, 32'h0000_1004, 32'h0, 0, 2, 32'h1234_5678, 1'b1, st, cw, cs, cr, ca);
        check_vec("fw_stalls", st, 32'd4);
        #1;
        check_vec("fw_stall_after", {31'd0, mem_stall}, 32'd0);
        check_vec("fw_rdata", mem_rdata, 32'hFFFF_8001);
        @(negedge clk);

        // minimum latency: both handshakes in REQ
        run_access(1'b0, SZ_W, 1'b0, 32'h0000_3000, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0, st, cw, cs, cr, ca);
        check_vec("min_stalls", st, 32'd2);
        retire(0, 32'hCAFE_F00D);

        // byte store to lane 1
        run_access(1'b1, SZ_B, 1'b0, 32'h0000_1001, 32'h1234_565A, 2, 0, 32'h0, 1'b0, st, cw, cs, cr, ca);
        check_vec("bs_wdata", cw, 32'h5A5A_5A5A);
        check_vec("bs_wstrb", {28'd0, cs}, 32'h0000_0002);
        check_vec("bs_stalls", st, 32'd4);
        retire(0, 32'hCAFE_F00D);

        // reset pulsed while in REQ
        mem_en = 1'b1; mem_we = 1'b0; mem_size = SZ_W; mem_addr = 32'h0000_4000;
        @(negedge clk);
        #1;
        check_vec("rr_req_before", {31'd0, data_req}, 32'd1);
        rst = 1'b0;
        #1;
        check_vec("rr_req", {31'd0, data_req}, 32'd0);
        check_vec("rr_stall", {31'd0, mem_stall}, 32'd0);
        check_vec("rr_rdata", mem_rdata, 32'd0);
        mem_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
